// File: rtl/mux_scan_pkg.sv
// Shared definitions for the scanning channel multiplexer.
package mux_scan_pkg;

    // Operating state: follow sel directly, or step through channels on a timer.
    typedef enum logic {
        ST_MANUAL = 1'b0,
        ST_SCAN   = 1'b1
    } state_t;

    // Ceiling log2, used to check that the select and prescaler widths are wide enough.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r_bits;
        longint unsigned r_span;
        r_bits = 0;
        r_span = 1;
        while (r_span < longint'(value)) begin
            r_span = r_span << 1;
            r_bits = r_bits + 1;
        end
        return r_bits;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running divider for the auto-scan rate: counts enabled cycles and flags the last one.
import mux_scan_pkg::*;

module scan_prescaler #(
    parameter int PRESC = 50000000,
    parameter int PW    = 26
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tick
);

    localparam logic [PW-1:0] LP_LAST = PW'(PRESC - 1);

    logic [PW-1:0] r_count;
    logic          w_last;

    assign w_last = (r_count == LP_LAST);
    // The tick only counts while enabled, so a held count never fires.
    assign o_tick = i_en && w_last;

    // Count enabled cycles, wrapping to zero on the terminal value; clear wins over enable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en) begin
            if (w_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_scan.sv
// N-channel, W-bit registered multiplexer with an optional timed auto-scan mode.
import mux_scan_pkg::*;

module mux_scan #(
    parameter int W     = 2,
    parameter int N     = 4,
    parameter int SW    = 2,
    parameter int PRESC = 50000000,
    parameter int PW    = 26
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic [N*W-1:0]  i_din,
    input  logic [SW-1:0]   i_sel,
    input  logic            i_mode,
    input  logic            i_hold,
    output logic [W-1:0]    o_mux_out,
    output logic [SW-1:0]   o_ch_out,
    output logic            o_step,
    output logic            o_dbg_state
);

    // Parameter sanity: the select port must address every channel, the counter must reach PRESC-1.
    if (SW < int'(clog2(N))) begin : g_bad_sw
        $error("mux_scan: SW too narrow for N channels");
    end
    if (PW < int'(clog2(PRESC))) begin : g_bad_pw
        $error("mux_scan: PW too narrow for PRESC");
    end

    localparam logic [SW-1:0] LP_LAST_CH = SW'(N - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [SW-1:0] r_ch;
    logic [SW-1:0] w_ch_nxt;
    logic [SW-1:0] w_sel_eff;
    logic [W-1:0]  r_data;
    logic [W-1:0]  w_data_nxt;
    logic          r_step;
    logic          w_step_nxt;
    logic          w_clr;
    logic          w_en;
    logic          w_tick;

    // Out-of-range selects fall back to channel 0 so ch_out never names a missing channel.
    assign w_sel_eff = (int'(i_sel) < N) ? i_sel : '0;

    scan_prescaler #(
        .PRESC (PRESC),
        .PW    (PW)
    ) u_presc (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (w_clr),
        .i_en    (w_en),
        .o_tick  (w_tick)
    );

    // State follows mode; any change of state restarts the prescaler. It only runs
    // while staying in SCAN unheld, so a mode drop on the terminal cycle cannot step.
    always_comb begin
        w_state_nxt = i_mode ? ST_SCAN : ST_MANUAL;
        w_clr       = (w_state_nxt != r_state);
        w_en        = (r_state == ST_SCAN) && i_mode && !i_hold;
    end

    // Next channel, step pulse and data: data is always fetched for the channel that
    // will be shown, so mux_out and ch_out stay paired and din changes show in one cycle.
    always_comb begin
        w_ch_nxt   = r_ch;
        w_step_nxt = 1'b0;
        w_data_nxt = '0;
        if ((r_state == ST_MANUAL) || !i_mode) begin
            w_ch_nxt = w_sel_eff;
        end else if (w_tick) begin
            w_ch_nxt   = (r_ch == LP_LAST_CH) ? '0 : r_ch + 1'b1;
            w_step_nxt = 1'b1;
        end
        for (int i = 0; i < N; i++) begin
            if (w_ch_nxt == SW'(i)) begin
                w_data_nxt = i_din[i*W +: W];
            end
        end
    end

    // Register state, channel, data and step so no input reaches an output combinationally.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= ST_MANUAL;
            r_ch    <= '0;
            r_data  <= '0;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ch    <= w_ch_nxt;
            r_data  <= w_data_nxt;
            r_step  <= w_step_nxt;
        end
    end

    assign o_mux_out   = r_data;
    assign o_ch_out    = r_ch;
    assign o_step      = r_step;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mux_scan.sv
// Directed-vector bench for mux_scan: each vector carries its hand-computed outputs,
// which a negedge monitor compares one cycle after the vector is applied.
module tb_mux_scan;

    localparam int W     = 2;
    localparam int N     = 4;
    localparam int SW    = 2;
    localparam int PRESC = 4;
    localparam int PW    = 3;

    // Channel i holds value i.
    localparam logic [7:0] D_ID  = 8'he4;  // {3,2,1,0}
    localparam logic [7:0] D_CH2 = 8'hd4;  // {3,1,1,0}
    localparam logic [7:0] D_CH3 = 8'h24;  // {0,2,1,0}

    logic           clk;
    logic           rst_n;
    logic [N*W-1:0] din;
    logic [SW-1:0]  sel;
    logic           mode;
    logic           hold;
    logic [W-1:0]   mux_out;
    logic [SW-1:0]  ch_out;
    logic           step;
    logic           dbg_state;

    logic [W+SW:0]  exp_q[$];
    int             n_vec;
    int             n_err;

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        rst_n = 1'b0;
        din   = D_ID;
        sel   = '0;
        mode  = 1'b1;
        hold  = 1'b0;
    end

    mux_scan #(
        .W     (W),
        .N     (N),
        .SW    (SW),
        .PRESC (PRESC),
        .PW    (PW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_din       (din),
        .i_sel       (sel),
        .i_mode      (mode),
        .i_hold      (hold),
        .o_mux_out   (mux_out),
        .o_ch_out    (ch_out),
        .o_step      (step),
        .o_dbg_state (dbg_state)
    );

    // ---------------- driver ----------------
    // Apply one vector just after a falling edge and queue the outputs expected after the next rising edge.
    task automatic drive(input logic v_rst_n, input logic v_mode, input logic v_hold,
                         input logic [SW-1:0] v_sel, input logic [N*W-1:0] v_din,
                         input logic [W-1:0] e_mux, input logic [SW-1:0] e_ch, input logic e_step);
        @(negedge clk);
        #1;
        rst_n = v_rst_n;
        mode  = v_mode;
        hold  = v_hold;
        sel   = v_sel;
        din   = v_din;
        exp_q.push_back({e_mux, e_ch, e_step});
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [W+SW:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if ({mux_out, ch_out, step} !== e) begin
                n_err++;
                $display("FAIL vec%0d t=%0t: got mux_out=%0d ch_out=%0d step=%0d, expected mux_out=%0d ch_out=%0d step=%0d",
                         n_vec, $time, mux_out, ch_out, step, e[W+SW:SW+1], e[SW:1], e[0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [SW-1:0] c;
        int            wait_cnt;
        n_vec = 0;
        n_err = 0;

        // Reset held two edges with mode=1: everything stays zero.
        drive(0, 1, 0, 0, D_ID, 0, 0, 0);
        drive(0, 1, 0, 0, D_ID, 0, 0, 0);
        // Release: enter SCAN on channel 0, first advance four edges later.
        drive(1, 1, 0, 0, D_ID, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            c = SW'((k / 4) % 4);
            drive(1, 1, 0, 0, D_ID, c, c, (k % 4) == 0);
        end

        // Manual: sel=2, then change channel 2's data, then sel=3, then back to 0.
        drive(1, 0, 0, 2, D_ID,  2, 2, 0);
        drive(1, 0, 0, 2, D_CH2, 1, 2, 0);
        drive(1, 0, 0, 3, D_CH2, 3, 3, 0);
        drive(1, 0, 0, 0, D_ID,  0, 0, 0);

        // Auto-scan from channel 0; sel is ignored once scanning.
        drive(1, 1, 0, 0, D_ID, 0, 0, 0);
        for (int k = 1; k <= 13; k++) begin
            c = SW'((k / 4) % 4);
            drive(1, 1, 0, 2, D_ID, c, c, (k % 4) == 0);
        end

        // Hold 10 cycles on channel 3 (prescaler at 1); data still tracks din.
        for (int i = 0; i < 10; i++) begin
            if (i < 5) drive(1, 1, 1, 2, D_ID,  3, 3, 0);
            else       drive(1, 1, 1, 2, D_CH3, 0, 3, 0);
        end
        // Release: two more counts, then wrap 3 -> 0.
        drive(1, 1, 0, 2, D_ID, 3, 3, 0);
        drive(1, 1, 0, 2, D_ID, 3, 3, 0);
        drive(1, 1, 0, 2, D_ID, 0, 0, 1);

        // Hold exactly on the terminal cycle: step deferred until release.
        drive(1, 1, 0, 2, D_ID, 0, 0, 0);
        drive(1, 1, 0, 2, D_ID, 0, 0, 0);
        drive(1, 1, 0, 2, D_ID, 0, 0, 0);
        drive(1, 1, 1, 2, D_ID, 0, 0, 0);
        drive(1, 1, 1, 2, D_ID, 0, 0, 0);
        drive(1, 1, 0, 2, D_ID, 1, 1, 1);

        // Mode drop on the terminal count with sel=1: manual wins, no step.
        drive(1, 1, 0, 0, D_ID, 1, 1, 0);
        drive(1, 1, 0, 0, D_ID, 1, 1, 0);
        drive(1, 1, 0, 0, D_ID, 1, 1, 0);
        drive(1, 0, 0, 1, D_ID, 1, 1, 0);
        // Back to scan: first advance to channel 2 a full period later.
        drive(1, 1, 0, 1, D_ID, 1, 1, 0);
        drive(1, 1, 0, 1, D_ID, 1, 1, 0);
        drive(1, 1, 0, 1, D_ID, 1, 1, 0);
        drive(1, 1, 0, 1, D_ID, 1, 1, 0);
        drive(1, 1, 0, 1, D_ID, 2, 2, 1);

        // Reset mid-scan at channel 2, prescaler 2.
        drive(1, 1, 0, 0, D_ID, 2, 2, 0);
        drive(1, 1, 0, 0, D_ID, 2, 2, 0);
        drive(0, 1, 0, 0, D_ID, 0, 0, 0);
        drive(1, 1, 0, 0, D_ID, 0, 0, 0);
        drive(1, 1, 0, 0, D_ID, 0, 0, 0);
        drive(1, 1, 0, 0, D_ID, 0, 0, 0);
        drive(1, 1, 0, 0, D_ID, 0, 0, 0);
        drive(1, 1, 0, 0, D_ID, 1, 1, 1);

        // Drain the scoreboard with a bounded wait.
        wait_cnt = 0;
        while (exp_q.size() > 0 && wait_cnt < 10) begin
            @(posedge clk);
            wait_cnt++;
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expected vectors never checked, required 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mux_scan.md
Name: mux_scan

Overview:
- Parametrised successor to the team's 2-bit 4:1 display multiplexer: N channels of W bits, registered output.
- Adds an auto-scan mode that cycles through the channels at a prescaled rate, with a hold input that freezes scanning.
- Sits between the data sources (switches, counters, registers) and the display/LED driver on the lab board.

Parameters:
- W, 2, width of each channel in bits (>=1).
- N, 4, number of channels (>=2).
- SW, 2, width of the sel and ch_out ports; must satisfy 2**SW >= N.
- PRESC, 50000000, clock cycles per scan step in auto mode (>=1).
- PW, 26, prescaler counter width; must satisfy 2**PW >= PRESC.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous reset, active low.
- din  in  N*W  packed channel data; channel i is din[i*W +: W].
- sel  in  SW  channel select, used in manual mode.
- mode  in  1  0 = manual (sel drives the channel), 1 = auto-scan.
- hold  in  1  in SCAN, freezes the prescaler and the channel; ignored in MANUAL.
- mux_out  out  W  registered data of the current channel.
- ch_out  out  SW  index of the channel currently shown on mux_out.
- step  out  1  one-cycle pulse when auto-scan advances the channel.

Behaviour:
- Interface: one clock (clk). Reset rst_n is synchronous and active low.
- Reset (rst_n=0 at a rising edge): mux_out=0, ch_out=0, step=0, prescaler=0, state=MANUAL. Reset asserted mid-scan takes effect at the next edge with no partial step.
- State machine: two states, MANUAL and SCAN.
  - MANUAL -> SCAN when mode=1 at an edge.
  - SCAN -> MANUAL when mode=0 at an edge.
  - Either transition clears the prescaler.
- Channel sanitising: sel_eff = sel if sel < N, else 0.
- MANUAL, every edge:
  - ch_out <= sel_eff; mux_out <= din[sel_eff].
  - Latency is 1 cycle from sel/din to mux_out.
  - step = 0.
- Entering SCAN: scanning starts from the current ch_out; there is no jump to channel 0.
- SCAN with hold=0:
  - Prescaler increments each edge.
  - When the prescaler equals PRESC-1: prescaler <= 0; ch_out <= (ch_out==N-1) ? 0 : ch_out+1; step <= 1 for exactly that cycle.
  - Otherwise step <= 0.
  - With PRESC=1 the channel advances every cycle and step stays high.
- SCAN with hold=1: prescaler and ch_out are held; step <= 0.
- Data tracking: in all states mux_out <= din[next ch_out]. mux_out and ch_out always refer to the same channel in the same cycle, and din changes propagate in 1 cycle even while ch_out is held.
- Wrap-around: N-1 -> 0. ch_out is never >= N.
- Simultaneous events:
  - mode 1->0 on a prescaler terminal cycle: MANUAL wins; no step, ch_out <= sel_eff.
  - hold=1 on the terminal cycle: no advance; the step occurs on the first cycle after hold releases.
- No combinational path from any input to any output.

Decomposition:
- Shared package mux_scan_pkg:
  - state encoding constants ST_MANUAL=0, ST_SCAN=1;
  - a clog2 constant function used for SW/PW checks.
- Sub-module scan_prescaler (params PRESC, PW; ports clk, rst_n, clr, en, tick).
  - tick is high when count==PRESC-1 and en=1.
- mux_scan holds the FSM, the channel register and the output data register.

Test Plan (W=2, N=4, SW=2, PRESC=4, PW=3; din = {2'd3,2'd2,2'd1,2'd0}, i.e. channel i holds value i):
- Reset: rst_n=0 for 2 edges with mode=1 -> mux_out=0, ch_out=0, step=0; release -> scan begins from ch 0.
- Manual: mode=0, sel=2 -> after 1 edge mux_out=2, ch_out=2. Change channel 2's data to 1 -> mux_out=1 one edge later.
- Auto-scan: mode=1 from ch 0 -> ch_out goes 1,2,3,0 every 4 cycles; step pulses once per advance; mux_out equals ch_out each cycle.
- Hold: hold=1 for 10 cycles on ch 3 -> ch_out stays 3, step stays 0. Release -> advance to 0 after the remaining prescaler count.
- Mode switch mid-scan: switch to mode=0 at the terminal count with sel=1 -> ch_out=1, no step pulse. Return to mode=1 -> first advance 4 cycles later to ch 2.
- Reset mid-scan: rst_n=0 for 1 edge at ch 2, prescaler=2 -> all outputs 0 next cycle; the first advance occurs a full 4 cycles after release.
